// File: rtl/ll_cmd_arbiter.sv
// Round-robin arbiter that lets REQ_CNT requesters share one linked-list
// hash-table engine. Commands go through a registered output stage. Results
// return in order and are steered back to the requester that issued the
// command, using a FIFO of requester indices (tags).
module ll_cmd_arbiter #(
    parameter int REQ_CNT   = 4,
    parameter int KEY_WIDTH = 9,
    parameter int TAG_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REQ_CNT-1:0]             req_valid_i,
    input  logic [REQ_CNT*KEY_WIDTH-1:0]   req_key_i,
    input  logic [REQ_CNT*2-1:0]           req_opcode_i,
    output logic [REQ_CNT-1:0]             req_ready_o,
    output logic                           cmd_valid_o,
    output logic [KEY_WIDTH-1:0]           cmd_key_o,
    output logic [1:0]                     cmd_opcode_o,
    input  logic                           cmd_ready_i,
    input  logic                           res_valid_i,
    input  logic [2:0]                     res_rescode_i,
    output logic                           res_ready_o,
    output logic [REQ_CNT-1:0]             resp_valid_o,
    output logic [2:0]                     resp_rescode_o,
    input  logic [REQ_CNT-1:0]             resp_ready_i,
    output logic [$clog2(TAG_DEPTH):0]     outstanding_o,
    output logic                           orphan_err_o
);

    localparam int IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam int TAG_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(TAG_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TAG_W-1:0] PTR_ONE   = TAG_W'(1);

    // Output stage and bookkeeping registers.
    logic                 cmd_valid_q, cmd_valid_d;
    logic [KEY_WIDTH-1:0] cmd_key_q,   cmd_key_d;
    logic [1:0]           cmd_opcode_q, cmd_opcode_d;
    logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [TAG_W-1:0]     wr_ptr_q,    wr_ptr_d;
    logic [TAG_W-1:0]     rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]     count_q,     count_d;
    logic                 orphan_q,    orphan_d;
    logic [IDX_W-1:0]     tag_mem_q [TAG_DEPTH];
    logic [IDX_W-1:0]     tag_mem_d [TAG_DEPTH];

    logic                 gnt_found;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 can_load;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [IDX_W-1:0]     head_idx;

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            if (!gnt_found && req_valid_i[(int'(rr_ptr_q) + k) % REQ_CNT]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'((int'(rr_ptr_q) + k) % REQ_CNT);
            end
        end
    end

    // Grant qualification: the full check uses the registered count, so a
    // same-cycle pop does not open a slot until the following cycle.
    always_comb begin
        can_load = !cmd_valid_q || cmd_ready_i;
        push     = !rst_i && gnt_found && can_load && (count_q < DEPTH_C);
        req_ready_o = '0;
        for (int i = 0; i < REQ_CNT; i++) begin
            if (push && (gnt_idx == IDX_W'(i))) begin
                req_ready_o[i] = 1'b1;
            end
        end
    end

    // Result steering toward the requester at the head of the tag FIFO.
    always_comb begin
        fifo_empty     = (count_q == '0);
        head_idx       = tag_mem_q[rd_ptr_q];
        resp_valid_o   = '0;
        resp_rescode_o = res_rescode_i;
        res_ready_o    = 1'b0;
        if (!rst_i) begin
            if (fifo_empty) begin
                res_ready_o = 1'b1;
            end else begin
                for (int i = 0; i < REQ_CNT; i++) begin
                    if (head_idx == IDX_W'(i)) begin
                        resp_valid_o[i] = res_valid_i;
                        res_ready_o     = resp_ready_i[i];
                    end
                end
            end
        end
        pop = res_valid_i && res_ready_o && !fifo_empty;
    end

    // Next-state for output stage, pointers, count and orphan flag.
    always_comb begin
        cmd_valid_d  = cmd_valid_q;
        cmd_key_d    = cmd_key_q;
        cmd_opcode_d = cmd_opcode_q;
        rr_ptr_d     = rr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        orphan_d     = orphan_q;
        tag_mem_d    = tag_mem_q;

        if (push) begin
            cmd_valid_d  = 1'b1;
            cmd_key_d    = req_key_i[int'(gnt_idx)*KEY_WIDTH +: KEY_WIDTH];
            cmd_opcode_d = req_opcode_i[int'(gnt_idx)*2 +: 2];
            rr_ptr_d     = IDX_W'((int'(gnt_idx) + 1) % REQ_CNT);
            tag_mem_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
        end else if (cmd_ready_i) begin
            cmd_valid_d  = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (!rst_i && res_valid_i && fifo_empty) begin
            orphan_d = 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_valid_q  <= 1'b0;
            cmd_key_q    <= '0;
            cmd_opcode_q <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            orphan_q     <= 1'b0;
        end else begin
            cmd_valid_q  <= cmd_valid_d;
            cmd_key_q    <= cmd_key_d;
            cmd_opcode_q <= cmd_opcode_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            orphan_q     <= orphan_d;
        end
    end

    // Tag storage needs no reset; entries are only read below the count.
    always_ff @(posedge clk_i) begin
        tag_mem_q <= tag_mem_d;
    end

    assign cmd_valid_o   = cmd_valid_q;
    assign cmd_key_o     = cmd_key_q;
    assign cmd_opcode_o  = cmd_opcode_q;
    assign outstanding_o = count_q;
    assign orphan_err_o  = orphan_q;

endmodule

// File: tb/tb_ll_cmd_arbiter.sv
module tb_ll_cmd_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [35:0] req_key_i;
    logic [7:0]  req_opcode_i;
    logic [3:0]  req_ready_o;
    logic        cmd_valid_o;
    logic [8:0]  cmd_key_o;
    logic [1:0]  cmd_opcode_o;
    logic        cmd_ready_i;
    logic        res_valid_i;
    logic [2:0]  res_rescode_i;
    logic        res_ready_o;
    logic [3:0]  resp_valid_o;
    logic [2:0]  resp_rescode_o;
    logic [3:0]  resp_ready_i;
    logic [3:0]  outstanding_o;
    logic        orphan_err_o;

    int n_cmp = 0;
    int n_err = 0;

    ll_cmd_arbiter #(.REQ_CNT(4), .KEY_WIDTH(9), .TAG_DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_key_i(req_key_i), .req_opcode_i(req_opcode_i),
        .req_ready_o(req_ready_o),
        .cmd_valid_o(cmd_valid_o), .cmd_key_o(cmd_key_o), .cmd_opcode_o(cmd_opcode_o),
        .cmd_ready_i(cmd_ready_i),
        .res_valid_i(res_valid_i), .res_rescode_i(res_rescode_i), .res_ready_o(res_ready_o),
        .resp_valid_o(resp_valid_o), .resp_rescode_o(resp_rescode_o), .resp_ready_i(resp_ready_i),
        .outstanding_o(outstanding_o), .orphan_err_o(orphan_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_i   = '0;
        req_key_i     = {9'h013, 9'h012, 9'h011, 9'h010};
        req_opcode_i  = '0;
        cmd_ready_i   = 1'b1;
        res_valid_i   = 1'b0;
        res_rescode_i = '0;
        resp_ready_i  = 4'hF;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        req_valid_i = 4'hF;
        res_valid_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready got %b exp 0000", req_ready_o); end
        n_cmp++; if (resp_valid_o !== 4'b0000) begin n_err++; $display("FAIL reset_resp_valid got %b exp 0000", resp_valid_o); end
        n_cmp++; if (res_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_res_ready got %b exp 0", res_ready_o); end
        step();
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid_o); end
        n_cmp++; if (cmd_key_o !== 9'h000 || cmd_opcode_o !== 2'd0) begin n_err++; $display("FAIL reset_cmd_fields got %h/%0d exp 000/0", cmd_key_o, cmd_opcode_o); end
        n_cmp++; if (outstanding_o !== 4'd0) begin n_err++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
        n_cmp++; if (orphan_err_o !== 1'b0) begin n_err++; $display("FAIL reset_orphan got %b exp 0", orphan_err_o); end
        idle_inputs();
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid_i = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (req_ready_o !== (4'b0001 << (k % 4))) begin n_err++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready_o, 4'b0001 << (k % 4)); end
            step();
            n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_key_o !== 9'(9'h010 + (k % 4))) begin n_err++; $display("FAIL rr_cmd[%0d] got v=%b key=%h exp v=1 key=%h", k, cmd_valid_o, cmd_key_o, 9'(9'h010 + (k % 4))); end
        end
        n_cmp++; if (outstanding_o !== 4'd6) begin n_err++; $display("FAIL rr_outstanding got %0d exp 6", outstanding_o); end
        idle_inputs();
    endtask

    task automatic test_single_insert();
        do_reset();
        step();
        step();
        req_valid_i = 4'b0100;
        req_key_i[18 +: 9] = 9'h1A5;
        req_opcode_i[4 +: 2] = 2'd0;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0100) begin n_err++; $display("FAIL ins_grant got %b exp 0100", req_ready_o); end
        step();
        req_valid_i = '0;
        n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_key_o !== 9'h1A5 || cmd_opcode_o !== 2'd0) begin n_err++; $display("FAIL ins_cmd got v=%b key=%h op=%0d exp v=1 key=1a5 op=0", cmd_valid_o, cmd_key_o, cmd_opcode_o); end
        n_cmp++; if (outstanding_o !== 4'd1) begin n_err++; $display("FAIL ins_outstanding got %0d exp 1", outstanding_o); end
        step();
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL ins_clear got %b exp 0", cmd_valid_o); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        cmd_ready_i = 1'b0;
        req_valid_i = 4'b0001;
        req_key_i[0 +: 9] = 9'h0AA;
        req_opcode_i[0 +: 2] = 2'd1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL bp_first_grant got %b exp 0001", req_ready_o); end
        step();
        req_valid_i = 4'b0011;
        req_key_i[9 +: 9] = 9'h155;
        req_opcode_i[2 +: 2] = 2'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ready[%0d] got %b exp 0000", k, req_ready_o); end
            n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_key_o !== 9'h0AA || cmd_opcode_o !== 2'd1) begin n_err++; $display("FAIL bp_hold[%0d] got v=%b key=%h op=%0d exp v=1 key=0aa op=1", k, cmd_valid_o, cmd_key_o, cmd_opcode_o); end
            step();
        end
        cmd_ready_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0010) begin n_err++; $display("FAIL bp_resume_grant got %b exp 0010", req_ready_o); end
        step();
        req_valid_i = '0;
        n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_key_o !== 9'h155 || cmd_opcode_o !== 2'd2) begin n_err++; $display("FAIL bp_resume_cmd got v=%b key=%h op=%0d exp v=1 key=155 op=2", cmd_valid_o, cmd_key_o, cmd_opcode_o); end
        n_cmp++; if (outstanding_o !== 4'd2) begin n_err++; $display("FAIL bp_outstanding got %0d exp 2", outstanding_o); end
        idle_inputs();
    endtask

    task automatic test_full();
        do_reset();
        req_valid_i = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
        end
        n_cmp++; if (outstanding_o !== 4'd8) begin n_err++; $display("FAIL full_count got %0d exp 8", outstanding_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL full_ready got %b exp 0000", req_ready_o); end
        step();
        n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL full_drain got %b exp 0", cmd_valid_o); end
        res_valid_i = 1'b1;
        res_rescode_i = 3'd2;
        #1;
        n_cmp++; if (resp_valid_o !== 4'b0001 || res_ready_o !== 1'b1) begin n_err++; $display("FAIL full_result got rv=%b rr=%b exp rv=0001 rr=1", resp_valid_o, res_ready_o); end
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL full_same_cycle_pop got %b exp 0000", req_ready_o); end
        step();
        res_valid_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL full_after_pop got %b exp 0001", req_ready_o); end
        step();
        n_cmp++; if (cmd_valid_o !== 1'b1 || outstanding_o !== 4'd8) begin n_err++; $display("FAIL full_refill got v=%b cnt=%0d exp v=1 cnt=8", cmd_valid_o, outstanding_o); end
        idle_inputs();
    endtask

    task automatic test_resp_routing();
        do_reset();
        req_valid_i = 4'b0010;
        step();
        req_valid_i = 4'b1000;
        req_opcode_i[6 +: 2] = 2'd3;
        #1;
        n_cmp++; if (req_ready_o !== 4'b1000) begin n_err++; $display("FAIL route_grant3 got %b exp 1000", req_ready_o); end
        step();
        req_valid_i = '0;
        n_cmp++; if (cmd_key_o !== 9'h013 || cmd_opcode_o !== 2'd3) begin n_err++; $display("FAIL route_opcode3 got key=%h op=%0d exp key=013 op=3", cmd_key_o, cmd_opcode_o); end
        step();
        n_cmp++; if (outstanding_o !== 4'd2) begin n_err++; $display("FAIL route_count got %0d exp 2", outstanding_o); end
        res_valid_i = 1'b1;
        res_rescode_i = 3'd5;
        resp_ready_i = 4'b0000;
        #1;
        n_cmp++; if (resp_valid_o !== 4'b0010 || res_ready_o !== 1'b0 || resp_rescode_o !== 3'd5) begin n_err++; $display("FAIL route_stall got rv=%b rr=%b rc=%0d exp rv=0010 rr=0 rc=5", resp_valid_o, res_ready_o, resp_rescode_o); end
        step();
        n_cmp++; if (outstanding_o !== 4'd2) begin n_err++; $display("FAIL route_no_pop got %0d exp 2", outstanding_o); end
        resp_ready_i = 4'b0010;
        #1;
        n_cmp++; if (res_ready_o !== 1'b1) begin n_err++; $display("FAIL route_ready1 got %b exp 1", res_ready_o); end
        step();
        res_rescode_i = 3'd3;
        resp_ready_i = 4'b1000;
        #1;
        n_cmp++; if (resp_valid_o !== 4'b1000 || res_ready_o !== 1'b1 || outstanding_o !== 4'd1) begin n_err++; $display("FAIL route_second got rv=%b rr=%b cnt=%0d exp rv=1000 rr=1 cnt=1", resp_valid_o, res_ready_o, outstanding_o); end
        step();
        res_valid_i = 1'b0;
        n_cmp++; if (outstanding_o !== 4'd0 || orphan_err_o !== 1'b0) begin n_err++; $display("FAIL route_drained got cnt=%0d orphan=%b exp 0/0", outstanding_o, orphan_err_o); end
        idle_inputs();
    endtask

    task automatic test_orphan();
        do_reset();
        resp_ready_i = 4'b0000;
        res_valid_i = 1'b1;
        #1;
        n_cmp++; if (res_ready_o !== 1'b1 || resp_valid_o !== 4'b0000) begin n_err++; $display("FAIL orphan_drop got rr=%b rv=%b exp rr=1 rv=0000", res_ready_o, resp_valid_o); end
        step();
        res_valid_i = 1'b0;
        step();
        n_cmp++; if (orphan_err_o !== 1'b1) begin n_err++; $display("FAIL orphan_sticky got %b exp 1", orphan_err_o); end
        do_reset();
        n_cmp++; if (orphan_err_o !== 1'b0) begin n_err++; $display("FAIL orphan_cleared got %b exp 0", orphan_err_o); end
        req_valid_i = 4'b0001;
        step();
        req_valid_i = '0;
        n_cmp++; if (outstanding_o !== 4'd1) begin n_err++; $display("FAIL orphan_inflight got %0d exp 1", outstanding_o); end
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        n_cmp++; if (outstanding_o !== 4'd0) begin n_err++; $display("FAIL orphan_midreset got %0d exp 0", outstanding_o); end
        res_valid_i = 1'b1;
        step();
        res_valid_i = 1'b0;
        n_cmp++; if (orphan_err_o !== 1'b1) begin n_err++; $display("FAIL orphan_after_reset got %b exp 1", orphan_err_o); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        test_reset();
        test_round_robin();
        test_single_insert();
        test_backpressure();
        test_full();
        test_resp_routing();
        test_orphan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ll_cmd_arbiter.md
LL_CMD_ARBITER -- requirements
Module: ll_cmd_arbiter

Interface
REQ-001 SHALL have parameter REQ_CNT, default 4, the number of requesters sharing one linked-list hash-table engine.
REQ-002 SHALL have parameter KEY_WIDTH, default 9, the key width, equal to LL_KEY_WIDTH.
REQ-003 SHALL have parameter TAG_DEPTH, default 8 (power of 2), the maximum number of commands in flight.
REQ-004 SHALL have port clk_i  in  1  clock; one clock domain.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid_i  in  REQ_CNT  command valid, one bit per requester.
REQ-007 SHALL have port req_key_i  in  REQ_CNT*KEY_WIDTH  command key; requester i occupies slice i.
REQ-008 SHALL have port req_opcode_i  in  REQ_CNT*2  opcode per requester: 0 INSERT, 1 DELETE, 2 DEQ.
REQ-009 SHALL have port req_ready_o  out  REQ_CNT  command accept, one bit per requester.
REQ-010 SHALL have port cmd_valid_o  out  1  command valid toward the engine.
REQ-011 SHALL have port cmd_key_o  out  KEY_WIDTH  command key toward the engine.
REQ-012 SHALL have port cmd_opcode_o  out  2  command opcode toward the engine.
REQ-013 SHALL have port cmd_ready_i  in  1  engine accepts the command.
REQ-014 SHALL have port res_valid_i  in  1  engine result valid.
REQ-015 SHALL have port res_rescode_i  in  3  engine result code, encoded in ll_ht_rescode_t order 0..6.
REQ-016 SHALL have port res_ready_o  out  1  result accept toward the engine.
REQ-017 SHALL have port resp_valid_o  out  REQ_CNT  result valid, one bit per requester.
REQ-018 SHALL have port resp_rescode_o  out  3  result code, shared by all requesters.
REQ-019 SHALL have port resp_ready_i  in  REQ_CNT  requester accepts the result.
REQ-020 SHALL have port outstanding_o  out  $clog2(TAG_DEPTH)+1  count of commands in flight.
REQ-021 SHALL have port orphan_err_o  out  1  sticky flag: a result arrived with nothing in flight.

Function
REQ-022 SHALL arbitrate round-robin; the search starts at rr_ptr and rr_ptr moves to (granted index + 1) mod REQ_CNT after each grant.
REQ-023 SHALL grant at most one requester per cycle; req_ready_o SHALL be one-hot or zero.
REQ-024 SHALL assert req_ready_o[g] only for the granted g, and only when the output stage can load and outstanding_o < TAG_DEPTH.
REQ-025 SHALL treat the output stage as loadable when !cmd_valid_o or cmd_ready_i.
REQ-026 SHALL register cmd_valid_o, cmd_key_o and cmd_opcode_o; a command accepted in cycle N SHALL appear on cmd_* in cycle N+1.
REQ-027 SHALL hold cmd_key_o and cmd_opcode_o stable while cmd_valid_o=1 and cmd_ready_i=0.
REQ-028 SHALL clear cmd_valid_o after a handshake when no new grant occurs.
REQ-029 SHALL forward opcodes unchanged; opcode 3 is passed through and is a requester error.
REQ-030 SHALL push the granted index into an in-order tag FIFO of depth TAG_DEPTH on each req handshake.
REQ-031 SHALL decide the full check on the registered count, ignoring a same-cycle pop.
REQ-032 SHALL drive resp_valid_o[head] = res_valid_i combinationally when the tag FIFO is non-empty; all other bits SHALL be 0.
REQ-033 SHALL drive resp_rescode_o = res_rescode_i and res_ready_o = resp_ready_i[head] when the tag FIFO is non-empty.
REQ-034 SHALL pop the tag FIFO on the res_valid_i & res_ready_o handshake.
REQ-035 SHALL, with the tag FIFO empty, drive res_ready_o=1, drop the result, and set orphan_err_o.
REQ-036 SHALL update outstanding_o by +1 on a push, -1 on a pop, and leave it unchanged on a simultaneous push and pop.
REQ-037 SHALL wrap the tag FIFO pointers modulo TAG_DEPTH.

Reset
REQ-038 SHALL, while rst_i=1 at a clock edge, clear cmd_valid_o, outstanding_o, the FIFO pointers, rr_ptr and orphan_err_o, and set cmd_key_o and cmd_opcode_o to 0.
REQ-039 SHALL hold req_ready_o, resp_valid_o and res_ready_o at 0 during reset.
REQ-040 SHALL discard in-flight tags on reset mid-operation; a later engine result sets orphan_err_o.

Verification
REQ-041 Bench SHALL cover: all 4 requesters valid continuously, cmd_ready_i=1 -> grants 0,1,2,3,0,...; one cmd_valid_o per cycle.
REQ-042 Bench SHALL cover: requester 2 sends INSERT key 0x1A5 in cycle 5 -> cmd_valid_o=1, key 0x1A5, opcode 0 in cycle 6; outstanding_o=1.
REQ-043 Bench SHALL cover: cmd_ready_i=0 for 3 cycles with a pending command -> cmd_* stable, req_ready_o=0; it resumes after ready rises.
REQ-044 Bench SHALL cover: 8 commands issued with no results -> outstanding_o=8 and req_ready_o=0; one result returns -> the next grant follows one cycle after the pop.
REQ-045 Bench SHALL cover: commands from requesters 1 then 3 -> first result on resp_valid_o[1], second on resp_valid_o[3]; resp_ready_i[1]=0 stalls res_ready_o.
REQ-046 Bench SHALL cover: res_valid_i with outstanding_o=0, and again after reset mid-flight -> result dropped, orphan_err_o=1 until rst_i.
